// File: rtl/toeplitz_row_gen.sv
// -----------------------------------------------------------------------------
// toeplitz_row_gen
//   Builds Toeplitz matrix rows from a serial seed stream and writes them into
//   the row FIFO. Row 0 is the first ROW_W seed bits (first bit ends up as the
//   MSB). Each later row is the previous row shifted left by one, with the next
//   seed bit entering at bit 0. A full matrix consumes ROW_W+NUM_ROWS-1 seed
//   bits and produces NUM_ROWS FIFO writes, followed by a one-cycle done pulse.
//
//   State table
//     state | meaning
//     IDLE  | waiting for gen_en; counters and row register held at zero
//     FILL  | shifting in the first ROW_W seed bits
//     EMIT  | writing the current row once the FIFO has room
//     SHIFT | taking one more seed bit to form the next row
//     DONE  | last row written; pulse done and return to IDLE
//
// Ports
//   clk_in      single clock, rising edge
//   rst_n       asynchronous active-low reset
//   gen_en      start request, only looked at in IDLE
//   seed_bit    next seed bit
//   seed_valid  seed_bit valid this cycle
//   seed_ready  block accepts seed_bit this cycle (FILL / SHIFT)
//   fifo_full   row FIFO full, sampled only in EMIT
//   fifo_write  registered one-cycle write strobe
//   row_out     registered row data, stable while fifo_write is high
//   busy        high in every state except IDLE
//   done        registered one-cycle pulse after the last row is written
//
//   CNT_W must satisfy 2**CNT_W > max(ROW_W, NUM_ROWS).
// -----------------------------------------------------------------------------
module toeplitz_row_gen #(
    parameter int ROW_W    = 3072,
    parameter int NUM_ROWS = 4096,
    parameter int CNT_W    = 13
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             gen_en,
    input  logic             seed_bit,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             fifo_full,
    output logic             fifo_write,
    output logic [ROW_W-1:0] row_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_EMIT  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(ROW_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(NUM_ROWS - 1);

    logic [2:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] row_out_q, row_out_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic             fifo_write_q, fifo_write_d;
    logic             done_q, done_d;
    logic             xfer;

    assign seed_ready = (state_q == ST_FILL) || (state_q == ST_SHIFT);
    assign busy       = (state_q != ST_IDLE);
    assign xfer       = seed_valid && seed_ready;

    assign fifo_write = fifo_write_q;
    assign row_out    = row_out_q;
    assign done       = done_q;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        row_out_d    = row_out_q;
        fill_cnt_d   = fill_cnt_q;
        row_cnt_d    = row_cnt_q;
        fifo_write_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                row_d      = '0;
                fill_cnt_d = '0;
                row_cnt_d  = '0;
                if (gen_en) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (xfer) begin
                    row_d      = {row_q[ROW_W-2:0], seed_bit};
                    fill_cnt_d = fill_cnt_q + CNT_ONE;
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                // A full FIFO simply holds us here; nothing else moves.
                if (!fifo_full) begin
                    fifo_write_d = 1'b1;
                    row_out_d    = row_q;
                    row_cnt_d    = row_cnt_q + CNT_ONE;
                    state_d      = (row_cnt_q == ROW_LAST) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    row_d   = {row_q[ROW_W-2:0], seed_bit};
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            row_out_q    <= '0;
            fill_cnt_q   <= '0;
            row_cnt_q    <= '0;
            fifo_write_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            row_out_q    <= row_out_d;
            fill_cnt_q   <= fill_cnt_d;
            row_cnt_q    <= row_cnt_d;
            fifo_write_q <= fifo_write_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_toeplitz_row_gen.sv
module tb_toeplitz_row_gen;

    // small instance for directed/random scenarios, full-size for the long run
    localparam int SW = 8;
    localparam int SR = 4;
    localparam int SC = 4;
    localparam int S_NSEED = SW + SR - 1;

    localparam int LW = 3072;
    localparam int LR = 4096;
    localparam int LC = 13;
    localparam int L_NSEED = LW + LR - 1;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b1;
    always #5 clk_in = ~clk_in;

    // ---------------- small DUT signals ----------------
    logic          s_gen = 0, s_bit = 0, s_valid = 0, s_full = 0;
    logic          s_ready, s_wr, s_busy, s_done;
    logic [SW-1:0] s_row;

    // ---------------- large DUT signals ----------------
    logic          l_gen = 0, l_bit = 0, l_valid = 0, l_full = 0;
    logic          l_ready, l_wr, l_busy, l_done;
    logic [LW-1:0] l_row;

    toeplitz_row_gen #(.ROW_W(SW), .NUM_ROWS(SR), .CNT_W(SC)) dut_s (
        .clk_in(clk_in), .rst_n(rst_n), .gen_en(s_gen), .seed_bit(s_bit),
        .seed_valid(s_valid), .seed_ready(s_ready), .fifo_full(s_full),
        .fifo_write(s_wr), .row_out(s_row), .busy(s_busy), .done(s_done)
    );

    toeplitz_row_gen #(.ROW_W(LW), .NUM_ROWS(LR), .CNT_W(LC)) dut_l (
        .clk_in(clk_in), .rst_n(rst_n), .gen_en(l_gen), .seed_bit(l_bit),
        .seed_valid(l_valid), .seed_ready(l_ready), .fifo_full(l_full),
        .fifo_write(l_wr), .row_out(l_row), .busy(l_busy), .done(l_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- small DUT: stimulus state + scoreboard ----------------
    logic          s_seed [S_NSEED];
    logic [SW-1:0] s_q [$];
    logic [SW-1:0] s_exp;
    int  s_idx = 0, s_cyc = 0, s_mode = 0;
    int  s_wr_cnt = 0, s_done_cnt = 0, s_xfer_cnt = 0;
    bit  s_stall_mode = 0, s_stall_done = 0, s_expect_wr = 0;
    int  s_stall_left = 0, s_stall_cycles = 0;
    logic s_full_smp = 0, s_prev_wr = 0;

    // Reference: row r is the ROW_W-bit window of the seed stream starting at
    // seed bit r, with the earliest bit as the MSB.
    task automatic s_load_expected();
        s_q.delete();
        for (int r = 0; r < SR; r++) begin
            logic [SW-1:0] row;
            for (int j = 0; j < SW; j++) row[j] = s_seed[r + SW - 1 - j];
            s_q.push_back(row);
        end
    endtask

    always @(posedge clk_in) begin
        s_full_smp = s_full;
        if (rst_n && s_valid && s_ready) begin
            s_xfer_cnt++;
            s_idx++;
        end
    end

    always @(negedge clk_in) begin
        if (rst_n) begin
            if (s_expect_wr) begin
                chk("s_write_after_release", s_wr, 1);
                s_expect_wr = 0;
            end
            if (s_stall_mode && s_full_smp) begin
                s_stall_cycles++;
                chk("s_stall_no_write", s_wr, 0);
                chk("s_stall_ready_low", s_ready, 0);
            end
            if (s_wr) begin
                s_wr_cnt++;
                if (s_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL s_extra_write: got row 0x%0h, expected no write", s_row);
                end else begin
                    s_exp = s_q.pop_front();
                    chk("s_row", s_row, s_exp);
                end
                chk("s_write_while_full", s_full_smp, 0);
                chk("s_back_to_back", s_prev_wr, 0);
                if (s_stall_mode && !s_stall_done && s_wr_cnt == 1) begin
                    s_stall_left = 6;
                    s_stall_done = 1;
                end
            end
            if (s_done) s_done_cnt++;
        end
        s_prev_wr = s_wr;

        s_cyc++;
        if (s_stall_left > 0) begin
            s_full = 1;
            s_stall_left--;
        end else begin
            if (s_full && s_stall_mode) s_expect_wr = 1;
            s_full = 0;
        end
        if (s_idx < S_NSEED) begin
            s_valid = (s_mode == 0) || (s_cyc[0] == 1'b1);
            s_bit   = s_seed[s_idx];
        end else begin
            s_valid = 0;
            s_bit   = 0;
        end
    end

    task automatic run_small(input int mode, input bit stall, input bit busy_pulse,
                             input int stop_after, input string tag);
        bit finished;
        s_load_expected();
        s_wr_cnt = 0; s_done_cnt = 0; s_xfer_cnt = 0; s_idx = 0;
        s_mode = mode; s_stall_mode = stall; s_stall_done = 0;
        s_stall_cycles = 0; s_expect_wr = 0;
        @(negedge clk_in); #1 s_gen = 1;
        @(negedge clk_in); #1 s_gen = 0;
        finished = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_in); #1;
            s_gen = busy_pulse && (c == 3 || c == 12 || c == 15);
            if (stop_after > 0 && s_wr_cnt >= stop_after) begin finished = 1; break; end
            if (stop_after == 0 && s_done_cnt > 0) begin finished = 1; break; end
        end
        s_gen = 0;
        chk({tag, "_completed"}, finished, 1);
        if (stop_after == 0) begin
            repeat (4) @(negedge clk_in);
            #1;
            chk({tag, "_writes"}, s_wr_cnt, SR);
            chk({tag, "_done_pulses"}, s_done_cnt, 1);
            chk({tag, "_seed_transfers"}, s_xfer_cnt, S_NSEED);
            chk({tag, "_idle_busy"}, s_busy, 0);
            chk({tag, "_idle_done"}, s_done, 0);
            chk({tag, "_rows_left"}, s_q.size(), 0);
        end
    endtask

    task automatic s_seed_from(input logic [S_NSEED-1:0] v);
        for (int i = 0; i < S_NSEED; i++) s_seed[i] = v[S_NSEED-1-i];
    endtask

    task automatic s_seed_random();
        for (int i = 0; i < S_NSEED; i++) s_seed[i] = 1'($urandom_range(0, 1));
    endtask

    // ---------------- large DUT: stimulus state + scoreboard ----------------
    logic          l_seed [L_NSEED];
    logic [LW-1:0] l_q [$];
    logic [LW-1:0] l_exp;
    int  l_idx = 0, l_wr_cnt = 0, l_done_cnt = 0, l_xfer_cnt = 0;
    logic l_full_smp = 0, l_prev_wr = 0;

    always @(posedge clk_in) begin
        l_full_smp = l_full;
        if (rst_n && l_valid && l_ready) begin
            l_xfer_cnt++;
            l_idx++;
        end
    end

    always @(negedge clk_in) begin
        if (rst_n) begin
            if (l_wr) begin
                l_wr_cnt++;
                if (l_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL l_extra_write: got write %0d, expected none", l_wr_cnt);
                end else begin
                    l_exp = l_q.pop_front();
                    n_checks++;
                    if (l_row !== l_exp) begin
                        n_fail++;
                        $display("FAIL l_row %0d: got low64 0x%016h, expected low64 0x%016h",
                                 l_wr_cnt - 1, l_row[63:0], l_exp[63:0]);
                    end
                end
                chk("l_write_while_full", l_full_smp, 0);
                chk("l_back_to_back", l_prev_wr, 0);
            end
            if (l_done) l_done_cnt++;
        end
        l_prev_wr = l_wr;
        if (l_idx < L_NSEED) begin
            l_valid = 1;
            l_bit   = l_seed[l_idx];
        end else begin
            l_valid = 0;
            l_bit   = 0;
        end
        l_full = ($urandom_range(0, 99) < 20);
    end

    // ---------------- main sequence ----------------
    initial begin
        bit finished;

        #2 rst_n = 0;
        #2;
        chk("rst_s_write", s_wr, 0);
        chk("rst_s_row", s_row, 0);
        chk("rst_s_busy", s_busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_s_done", s_done, 0);
        chk("rst_l_write", l_wr, 0);
        chk("rst_l_row_any", |l_row, 0);
        chk("rst_l_busy", l_busy, 0);
        repeat (2) @(negedge clk_in);
        #1 rst_n = 1;

        // basic matrix: rows B3, 67, CE, 9D
        s_seed_from(11'b10110011101);
        run_small(0, 0, 0, 0, "t1");

        // FIFO stall while row 1 waits in EMIT
        run_small(0, 1, 0, 0, "t2");
        chk("t2_stall_cycles", s_stall_cycles, 6);

        // gapped seed stream
        run_small(1, 0, 0, 0, "t3");
        s_seed_random();
        run_small(1, 0, 0, 0, "t3r");

        // reset mid-matrix after the second write
        s_seed_random();
        run_small(0, 0, 0, 2, "t4a");
        rst_n = 0;
        #1;
        chk("t4_rst_write", s_wr, 0);
        chk("t4_rst_row", s_row, 0);
        chk("t4_rst_busy", s_busy, 0);
        chk("t4_rst_ready", s_ready, 0);
        chk("t4_rst_done", s_done, 0);
        @(negedge clk_in); #1 rst_n = 1;
        repeat (3) @(negedge clk_in);
        #1;
        chk("t4_no_restart", s_busy, 0);
        s_seed_random();
        run_small(0, 0, 0, 0, "t4b");

        // gen_en pulses while busy
        s_seed_from(11'b10110011101);
        run_small(0, 0, 1, 0, "t5");

        // full-size matrix, random seed, ~20% FIFO-full
        for (int i = 0; i < L_NSEED; i++) l_seed[i] = 1'($urandom_range(0, 1));
        l_q.delete();
        for (int r = 0; r < LR; r++) begin
            logic [LW-1:0] row;
            for (int j = 0; j < LW; j++) row[j] = l_seed[r + LW - 1 - j];
            l_q.push_back(row);
        end
        l_wr_cnt = 0; l_done_cnt = 0; l_xfer_cnt = 0; l_idx = 0;
        @(negedge clk_in); #1 l_gen = 1;
        @(negedge clk_in); #1 l_gen = 0;
        finished = 0;
        for (int c = 0; c < 60000; c++) begin
            @(negedge clk_in); #1;
            if (l_done_cnt > 0) begin finished = 1; break; end
        end
        chk("t6_completed", finished, 1);
        repeat (4) @(negedge clk_in);
        #1;
        chk("t6_writes", l_wr_cnt, LR);
        chk("t6_seed_transfers", l_xfer_cnt, L_NSEED);
        chk("t6_done_pulses", l_done_cnt, 1);
        chk("t6_idle_busy", l_busy, 0);
        chk("t6_rows_left", l_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
